// File: rtl/ps2_pkg.sv
// Shared types and timing helpers for the PS/2 host controller.
// All PS/2 timing constants are derived from the system clock frequency.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_INHIBIT,
    S_REQ,
    S_TX,
    S_ACK,
    S_WAIT_REL
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // 100 us clock inhibit before a host request
  function automatic int unsigned ps2_t_inh(input int unsigned clk_hz);
    return clk_hz / 10_000;
  endfunction

  // 5 us with data pulled low before the clock is released
  function automatic int unsigned ps2_t_req(input int unsigned clk_hz);
    return clk_hz / 200_000;
  endfunction

  function automatic int unsigned ps2_t_to(input int unsigned clk_hz, input int unsigned to_us);
    return (clk_hz / 1_000_000) * to_us;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded key events.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ps2_evt_fifo
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_host_if.sv
// Bidirectional PS/2 host: filtered line inputs, frame receiver, E0/F0 decoder,
// event FIFO and host-to-device command transmitter with ACK reporting.
module ps2_host_if
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter bit          RAW_MODE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [9:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_ovf
);
  localparam int unsigned T_INH = ps2_t_inh(CLK_HZ);
  localparam int unsigned T_REQ = ps2_t_req(CLK_HZ);
  localparam int unsigned T_TO  = ps2_t_to(CLK_HZ, TIMEOUT_US);
  localparam int unsigned T_MAX = (T_INH > T_TO) ? ((T_INH > T_REQ) ? T_INH : T_REQ)
                                                 : ((T_TO > T_REQ) ? T_TO : T_REQ);
  localparam int TW = $clog2(T_MAX + 1);

  // bit 0 = clock line, bit 1 = data line
  logic [1:0] pin_raw;
  logic [1:0] line_filt;
  assign pin_raw = {ps2_data_i, ps2_clk_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [1:0]            sync_reg;
    logic [FILTER_LEN-1:0] hist_reg;
    logic                  filt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_reg <= '1;
        hist_reg <= '1;
        filt_reg <= 1'b1;
      end else begin
        sync_reg <= {sync_reg[0], pin_raw[gi]};
        hist_reg <= FILTER_LEN'({hist_reg, sync_reg[1]});
        if (&hist_reg)       filt_reg <= 1'b1;
        else if (~|hist_reg) filt_reg <= 1'b0;
      end
    end
    assign line_filt[gi] = filt_reg;
  end

  logic clk_filt, data_filt, clk_prev_reg, fall;
  assign clk_filt  = line_filt[0];
  assign data_filt = line_filt[1];
  assign fall      = clk_prev_reg && !clk_filt;

  ps2_state_t state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [8:0]    shift_reg, shift_next;
  logic          clk_oe_reg, clk_oe_next, data_oe_reg, data_oe_next;
  logic          byte_vld_reg, byte_vld_next;
  logic [7:0]    byte_reg, byte_next;
  logic          ext_reg, ext_next, brk_reg, brk_next;
  logic          done_reg, done_next, err_reg, err_next;
  logic          perr_reg, perr_next, ferr_reg, ferr_next, ovf_reg;
  logic          timer_hit_to;

  assign timer_hit_to = (timer_reg == TW'(T_TO - 1));

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg + TW'(1);
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    clk_oe_next   = clk_oe_reg;
    data_oe_next  = data_oe_reg;
    byte_vld_next = 1'b0;
    byte_next     = byte_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    perr_next     = 1'b0;
    ferr_next     = 1'b0;
    tx_ready      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        timer_next = '0;
        tx_ready   = !fall;
        if (fall) begin
          if (data_filt) ferr_next = 1'b1;
          else begin
            state_next   = S_RX;
            bit_cnt_next = 4'd1;
          end
        end else if (tx_valid) begin
          shift_next  = {~^tx_data, tx_data};
          clk_oe_next = 1'b1;
          state_next  = S_INHIBIT;
        end
      end
      S_RX: begin
        if (fall) begin
          timer_next   = '0;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd10) begin
            state_next = S_IDLE;
            perr_next  = !(^shift_reg);
            ferr_next  = !data_filt;
            if ((^shift_reg) && data_filt) begin
              byte_vld_next = 1'b1;
              byte_next     = shift_reg[7:0];
            end
          end else begin
            shift_next = {data_filt, shift_reg[8:1]};
          end
        end else if (timer_hit_to) begin
          ferr_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (timer_reg == TW'(T_INH - 1)) begin
          timer_next   = '0;
          data_oe_next = 1'b1;
          state_next   = S_REQ;
        end
      end
      S_REQ: begin
        if (timer_reg == TW'(T_REQ - 1)) begin
          timer_next   = '0;
          clk_oe_next  = 1'b0;
          bit_cnt_next = 4'd0;
          state_next   = S_TX;
        end
      end
      S_TX: begin
        if (fall) begin
          timer_next   = '0;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd9) begin
            data_oe_next = 1'b0;
            state_next   = S_ACK;
          end else begin
            data_oe_next = !shift_reg[0];
            shift_next   = {1'b0, shift_reg[8:1]};
          end
        end else if (timer_hit_to) begin
          err_next     = 1'b1;
          data_oe_next = 1'b0;
          state_next   = S_IDLE;
        end
      end
      S_ACK: begin
        if (fall) begin
          timer_next = '0;
          done_next  = !data_filt;
          err_next   = data_filt;
          state_next = S_WAIT_REL;
        end else if (timer_hit_to) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_REL: begin
        if (clk_filt && data_filt) state_next = S_IDLE;
        else if (timer_hit_to) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Prefix decoder works on the byte registered at the stop-bit edge.
  logic       push, pop, fifo_full, fifo_empty;
  logic [9:0] push_data;

  always_comb begin
    push      = 1'b0;
    push_data = {ext_reg, brk_reg, byte_reg};
    ext_next  = ext_reg;
    brk_next  = brk_reg;
    if (byte_vld_reg) begin
      if (RAW_MODE) begin
        push      = 1'b1;
        push_data = {2'b00, byte_reg};
      end else if (byte_reg == PS2_EXT) begin
        ext_next = 1'b1;
      end else if (byte_reg == PS2_BRK) begin
        brk_next = 1'b1;
      end else begin
        push     = 1'b1;
        ext_next = 1'b0;
        brk_next = 1'b0;
      end
    end
  end

  assign pop = rx_ready && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      clk_prev_reg <= 1'b1;
      byte_vld_reg <= 1'b0;
      byte_reg     <= '0;
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      clk_prev_reg <= clk_filt;
      byte_vld_reg <= byte_vld_next;
      byte_reg     <= byte_next;
      ext_reg      <= ext_next;
      brk_reg      <= brk_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      ovf_reg      <= push && fifo_full && !pop;
    end
  end

  ps2_evt_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid    = !fifo_empty;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_done     = done_reg;
  assign tx_err      = err_reg;
  assign rx_perr     = perr_reg;
  assign rx_ferr     = ferr_reg;
  assign rx_ovf      = ovf_reg;

endmodule

// File: tb/tb_ps2_host_if.sv
// Directed bench for ps2_host_if: a device model drives/reads the open-drain pins
// and every result is compared against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_host_if;
  localparam int HALF      = 20;            // device half-period in system clocks
  localparam int LAT_VALID = 4 + 5;         // pin fall -> rx_valid: 2 sync + 4 hist + filt + 2
  localparam int T_TO_CLK  = 25 * 100;      // TIMEOUT_US=100 at 25 MHz

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       tx_ready, tx_done, tx_err, rx_valid, rx_perr, rx_ferr, rx_ovf;
  logic [9:0] rx_data;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_if #(
    .CLK_HZ(25_000_000), .FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_US(100), .RAW_MODE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovf(rx_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (rx_perr) perr_cnt++;
    if (rx_ferr) ferr_cnt++;
    if (rx_ovf)  ovf_cnt++;
    if (tx_done) done_cnt++;
    if (tx_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One device-to-host frame; lat = clocks from stop-bit pin fall to rx_valid
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop,
                            input int nbits, output int lat);
    logic [10:0] fr;
    fr  = {stop, (~^b) ^ flip, b, 1'b0};
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      dev_data = fr[i];
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (i == 10) begin
        for (int k = 1; k <= HALF; k++) begin
          @(posedge clk); #1;
          if (lat < 0 && rx_valid) lat = k;
        end
        @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [9:0] exp);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic dev_clock_read(output logic b);
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    b = ps2_data_i;
    dev_clk = 1'b1;
  endtask

  // Offer a command and measure inhibit/request phases until the clock is released
  task automatic tx_request(input logic [7:0] b, output int inh, output int req,
                            output logic start);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 10000) begin
      inh++;
      @(negedge clk);
    end
    req = 0;
    while (ps2_clk_oe && ps2_data_oe && req < 10000) begin
      req++;
      @(negedge clk);
    end
    start = ps2_data_i;
  endtask

  task automatic host_tx(input string tag, input logic [7:0] b, input logic ack_bit,
                         input logic [7:0] exp_byte);
    int inh, req, d0, e0, w;
    logic start;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_request(b, inh, req, start);
    check({tag, "_inhibit_clks"}, 32'(inh), 32'd2500);
    check({tag, "_req_clks"}, 32'(req), 32'd125);
    check({tag, "_start"}, 32'(start), 32'd0);
    for (int i = 0; i < 10; i++) dev_clock_read(bits[i]);
    check({tag, "_byte"}, 32'(bits[7:0]), 32'(exp_byte));
    check({tag, "_parity"}, 32'(bits[8]), 32'(~^exp_byte));
    check({tag, "_stop"}, 32'(bits[9]), 32'd1);
    dev_data = ack_bit;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    dev_data = 1'b1;
    w = 0;
    while (!tx_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    check({tag, "_ready_back"}, 32'(tx_ready), 32'd1);
    check({tag, "_done"}, 32'(done_cnt - d0), ack_bit ? 32'd0 : 32'd1);
    check({tag, "_err"}, 32'(err_cnt - e0), ack_bit ? 32'd1 : 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, c0, inh, req;
    logic start, b;
    logic [7:0] codes [9];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    repeat (4) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Make, break and extended-break events
    send_frame(8'h1C, 1'b0, 1'b1, 11, lat);
    pop_expect("make_1c", 10'h01C);
    check("empty_after_pop", 32'(rx_valid), 32'd0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, lat);
    check("f0_not_pushed", 32'(rx_valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, lat);
    pop_expect("brk_1c", 10'h11C);
    send_frame(8'hE0, 1'b0, 1'b1, 11, lat);
    send_frame(8'hF0, 1'b0, 1'b1, 11, lat);
    check("e0f0_not_pushed", 32'(rx_valid), 32'd0);
    send_frame(8'h75, 1'b0, 1'b1, 11, lat);
    check("valid_latency", 32'(lat), 32'(LAT_VALID));
    pop_expect("ext_brk_75", 10'h375);

    // Parity and stop errors
    c0 = perr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11, lat);
    check("perr_pulse", 32'(perr_cnt - c0), 32'd1);
    check("perr_fifo_empty", 32'(rx_valid), 32'd0);
    c0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 11, lat);
    check("stop_ferr_pulse", 32'(ferr_cnt - c0), 32'd1);
    check("stop_fifo_empty", 32'(rx_valid), 32'd0);

    // Frame stalls after start + 4 bits
    c0 = ferr_cnt;
    send_frame(8'h29, 1'b0, 1'b1, 5, lat);
    repeat (T_TO_CLK + 500) @(negedge clk);
    check("timeout_ferr", 32'(ferr_cnt - c0), 32'd1);
    send_frame(8'h29, 1'b0, 1'b1, 11, lat);
    pop_expect("after_to_29", 10'h029);

    // Host commands: ACK then NACK
    host_tx("tx_ed_ack", 8'hED, 1'b0, 8'hED);
    host_tx("tx_f4_nack", 8'hF4, 1'b1, 8'hF4);

    // FIFO overflow and ordering
    c0 = ovf_cnt;
    for (int i = 0; i < 8; i++) send_frame(codes[i], 1'b0, 1'b1, 11, lat);
    check("no_ovf_at_8", 32'(ovf_cnt - c0), 32'd0);
    send_frame(codes[8], 1'b0, 1'b1, 11, lat);
    check("ovf_at_9", 32'(ovf_cnt - c0), 32'd1);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("fifo_%0d", i), {2'b00, codes[i]});
    check("fifo_drained", 32'(rx_valid), 32'd0);

    // Reset in the middle of a transmit with an event pending
    send_frame(8'h1C, 1'b0, 1'b1, 11, lat);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    tx_request(8'h00, inh, req, start);
    for (int i = 0; i < 3; i++) dev_clock_read(b);
    check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    dev_clk = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("post_rst_rx_valid", 32'(rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
